subckt_sweep_ctrl: RTL
======================

Name: subckt_sweep_ctrl

Overview:
Sequencer that exhaustively drives a 4-input, 1-output combinational sub-circuit (inputs n_1..n_4, output n_9) through all 16 input patterns. It captures the response truth table and counts output and input switching activity for power characterisation. It sits in the per-sub-circuit characterisation harness, between the harness control register and the circuit under test.

Parameters:
SETTLE_CYCLES, 2, cycles each pattern is held before the response is sampled (legal range 1..255; 0 is illegal)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin sweep; accepted only in IDLE
abort  in  1  stop sweep and return to IDLE; highest priority after rst
pat  out  4  drives the sub-circuit: pat[0]=n_1, pat[1]=n_2, pat[2]=n_3, pat[3]=n_4
resp  in  1  sub-circuit output n_9
busy  out  1  high while a sweep is in progress
done  out  1  one-cycle pulse when a sweep completes normally
truth  out  16  truth[p] = resp sampled while pat==p
out_tgl  out  4  count of resp changes between consecutive samples
in_flip  out  5  total input bit flips applied across the sweep

Behaviour:
- Reset (async, rst=1): state=IDLE; pat=0, busy=0, done=0, truth=0, out_tgl=0, in_flip=0; internal idx=0, wait counter=0.
- FSM states: IDLE, SETTLE, DONE.
- IDLE -> SETTLE on start=1:
  - Clear truth, out_tgl and in_flip; set idx=0 and wait=0.
  - pat=order(0)=0 and busy=1 from the next cycle.
- SETTLE: hold pat=order(idx) for SETTLE_CYCLES cycles. On the edge where wait==SETTLE_CYCLES-1:
  - Write truth[order(idx)] <= resp.
  - If idx>0 and resp != previous sample, out_tgl += 1.
  - If idx==15, go to DONE.
  - Otherwise idx += 1, wait=0, pat=order(idx+1), and in_flip += popcount(order(idx) ^ order(idx+1)).
  - On all other SETTLE edges, wait += 1.
- DONE: one cycle with done=1, busy=0, pat=0, then unconditionally -> IDLE. A start seen in DONE is ignored.
- Latency: busy is high for exactly 16*SETTLE_CYCLES cycles. done pulses in the following cycle.
- Default order(i)=i (binary). in_flip final = 26 (15+7+3+1). Counters cannot overflow: out_tgl max 15, in_flip max 26.
- start while busy: ignored.
- abort=1 in SETTLE: next state IDLE, pat=0, busy=0, no done pulse. truth, out_tgl and in_flip keep their partial values. abort in IDLE or DONE: no effect, except that in DONE the done pulse still completes.
- start and abort both high in IDLE: abort wins and the block stays in IDLE.
- Results (truth, out_tgl, in_flip) are held stable in IDLE until the next accepted start.
- pat is registered, with no combinational path from resp or start to pat.
- resp is treated as synchronous to clk. No synchroniser is provided.

Optional Feature:
GRAY_ORDER_EN
- Defined: order(i) = i ^ (i>>1) (Gray sequence). Every step flips exactly one input, so final in_flip=15. truth stays indexed by pattern value, not by step.
- Undefined: binary order as above. No Gray logic is synthesised.

Test Plan:
- resp tied to pat[3], SETTLE_CYCLES=2, pulse start -> busy high for 32 cycles, then a 1-cycle done; truth=16'hFF00, out_tgl=1, in_flip=26 (with GRAY_ORDER_EN: truth=16'hFF00, out_tgl=1, in_flip=15).
- resp = XOR of pat[3:0], SETTLE_CYCLES=1 -> busy for 16 cycles; truth=16'h6996, out_tgl=10, in_flip=26 (with GRAY_ORDER_EN: out_tgl=15, in_flip=15).
- resp constant 1; run a sweep, then a second sweep -> both give truth=16'hFFFF and out_tgl=0; the second start clears the results first (truth reads 0 during the first pattern).
- Assert abort after pattern 5 is sampled (resp=pat[0]) -> IDLE next cycle, pat=0, no done pulse; truth=16'h002A, out_tgl=5.
- Pulse start during the sweep and during DONE -> ignored; exactly one done pulse; the sweep length is unchanged.
- Assert rst asynchronously mid-sweep -> all outputs 0 immediately, without waiting for a clock edge; a start after reset release runs a full normal sweep.

Source files
------------

// File: rtl/subckt_sweep_ctrl_if.sv
// Handshake and result bundle between the harness/sub-circuit side and the
// sweep sequencer.
interface subckt_sweep_ctrl_if;
  logic        start;
  logic        abort;
  logic [3:0]  pat;
  logic        resp;
  logic        busy;
  logic        done;
  logic [15:0] truth;
  logic [3:0]  out_tgl;
  logic [4:0]  in_flip;

  modport master (output start, abort, resp,
                  input  pat, busy, done, truth, out_tgl, in_flip);
  modport slave  (input  start, abort, resp,
                  output pat, busy, done, truth, out_tgl, in_flip);
endinterface

// File: rtl/subckt_sweep_ctrl.sv
// Exhaustive 16-pattern sweep of a 4-in/1-out sub-circuit: truth table capture
// plus output/input switching counts. Define GRAY_ORDER_EN for Gray stepping order.
module subckt_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  subckt_sweep_ctrl_if.slave sw
);
  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_e;

  localparam logic [7:0] LAST = 8'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  wait_q, wait_d;
  logic [3:0]  pat_q, pat_d;
  logic [15:0] truth_q, truth_d;
  logic [3:0]  tgl_q, tgl_d;
  logic [4:0]  flip_q, flip_d;
  logic        prev_q, prev_d;

  logic [3:0]  ord_cur, ord_nxt, diff;
  logic [2:0]  pc;

  function automatic logic [3:0] ord(input logic [3:0] i);
`ifdef GRAY_ORDER_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  assign ord_cur = ord(idx_q);
  assign ord_nxt = ord(idx_q + 4'd1);
  assign diff    = ord_cur ^ ord_nxt;

  always_comb begin
    pc = '0;
    for (int k = 0; k < 4; k++) pc = pc + {2'b00, diff[k]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wait_q  <= '0;
      pat_q   <= '0;
      truth_q <= '0;
      tgl_q   <= '0;
      flip_q  <= '0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      pat_q   <= pat_d;
      truth_q <= truth_d;
      tgl_q   <= tgl_d;
      flip_q  <= flip_d;
      prev_q  <= prev_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    pat_d   = pat_q;
    truth_d = truth_q;
    tgl_d   = tgl_q;
    flip_d  = flip_q;
    prev_d  = prev_q;
    case (state_q)
      IDLE: begin
        // abort outranks start, so a simultaneous pair leaves us idle
        if (sw.start && !sw.abort) begin
          state_d = SETTLE;
          truth_d = '0;
          tgl_d   = '0;
          flip_d  = '0;
          idx_d   = '0;
          wait_d  = '0;
          pat_d   = ord(4'd0);
        end
      end
      SETTLE: begin
        if (sw.abort) begin
          state_d = IDLE;
          pat_d   = '0;
        end else if (wait_q == LAST) begin
          truth_d[ord_cur] = sw.resp;
          prev_d           = sw.resp;
          if (idx_q != 4'd0 && sw.resp != prev_q) tgl_d = tgl_q + 4'd1;
          if (idx_q == 4'd15) begin
            state_d = DONE;
            pat_d   = '0;
          end else begin
            idx_d  = idx_q + 4'd1;
            wait_d = '0;
            pat_d  = ord_nxt;
            flip_d = flip_q + {2'b00, pc};
          end
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        pat_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sw.pat     = pat_q;
  assign sw.busy    = (state_q == SETTLE);
  assign sw.done    = (state_q == DONE);
  assign sw.truth   = truth_q;
  assign sw.out_tgl = tgl_q;
  assign sw.in_flip = flip_q;
endmodule
